// File: rtl/p1_rtl.sv
// p1_rtl: registered N-bit bitwise logic unit, operation fixed at elaboration by opcode.
module p1_rtl #(
  parameter int N = 4,
  parameter int unsigned opcode = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] in0,
  input  logic [N-1:0] in1,
  output logic [N-1:0] out,
  output logic         out_valid,
  output logic         zero
);
  localparam logic [2:0] op = opcode[2:0];
  logic [N-1:0] res;
  if (opcode > 7 || N < 1 || N > 64) begin : g_bad_param
    $fatal(1, "p1_rtl: illegal opcode or width");
  end
  always_comb
    case (op)
      3'd0:    res = in0 & in1;
      3'd1:    res = in0 | in1;
      3'd2:    res = in0 ^ in1;
      3'd3:    res = ~(in0 ^ in1);
      3'd4:    res = ~(in0 & in1);
      3'd5:    res = ~(in0 | in1);
      3'd6:    res = in0 & ~in1;
      default: res = in0;
    endcase
  // out and zero only load on accepted beats, so idle operands (even X) never reach them
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      zero      <= 1'b1;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out  <= res;
        zero <= ~|res;
      end
    end
endmodule

// File: tb/tb_p1_rtl.sv
// tb_p1_rtl: scoreboard bench for p1_rtl (OR unit) plus a per-opcode bank and an N=1 instance.
module tb_p1_rtl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in0 = '0;
  logic [3:0] in1 = '0;
  logic [3:0] out;
  logic       out_valid;
  logic       zero;
  int vectors = 0;
  int miscompares = 0;
  int pops = 0;
  logic [4:0] sb[$];
  logic       bv = 1'b0;
  logic [3:0] ba = 4'b1100;
  logic [3:0] bb = 4'b1010;
  logic [3:0] bo[8];
  logic [7:0] bvo;
  logic [7:0] bz;
  logic       n1_out;
  logic       n1_valid;
  logic       n1_zero;
  always #5 clk = ~clk;
  p1_rtl #(.N(4), .opcode(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in0(in0), .in1(in1),
    .out(out), .out_valid(out_valid), .zero(zero)
  );
  for (genvar g = 0; g < 8; g++) begin : g_op
    p1_rtl #(.N(4), .opcode(g)) u_op (
      .clk(clk), .rst_n(rst_n), .in_valid(bv), .in0(ba), .in1(bb),
      .out(bo[g]), .out_valid(bvo[g]), .zero(bz[g])
    );
  end
  p1_rtl #(.N(1), .opcode(2)) u_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(bv), .in0(ba[3]), .in1(bb[3]),
    .out(n1_out), .out_valid(n1_valid), .zero(n1_zero)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  task automatic beat(input logic [3:0] a, input logic [3:0] b, input logic [3:0] e);
    @(negedge clk);
    in_valid = 1'b1;
    in0 = a;
    in1 = b;
    sb.push_back({e, e == 4'b0000});
  endtask
  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in0 = 'x;
    in1 = 'x;
  endtask
  always @(posedge clk) begin
    logic [4:0] e;
    #1;
    if (rst_n && out_valid) begin
      if (sb.size() == 0) chk("unexpected out_valid", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("out", 32'(out), 32'(e[4:1]));
        chk("zero", 32'(zero), 32'(e[0]));
        pops++;
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    int p0;
    logic [3:0] a, b;
    logic [3:0] exp_op[8] = '{4'b1000, 4'b1110, 4'b0110, 4'b1001,
                              4'b0111, 4'b0001, 4'b0100, 4'b1100};
    #12;
    chk("reset out", 32'(out), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset zero", 32'(zero), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    beat(4'b0101, 4'b0011, 4'b0111);
    beat(4'b0000, 4'b0000, 4'b0000);
    idle();
    p0 = pops;
    for (int i = 0; i < 100; i++) begin
      a = 4'($urandom);
      b = 4'($urandom);
      beat(a, b, a | b);
    end
    idle();
    @(posedge clk);
    #2;
    chk("sweep back-to-back count", 32'(pops - p0), 32'd100);
    beat(4'b1111, 4'b0000, 4'b1111);
    idle();
    @(posedge clk);
    #2;
    chk("hold out", 32'(out), 32'b1111);
    chk("hold out_valid", 32'(out_valid), 32'd0);
    chk("hold zero", 32'(zero), 32'd0);
    @(negedge clk);
    bv = 1'b1;
    @(negedge clk);
    bv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("opcode %0d out", i), 32'(bo[i]), 32'(exp_op[i]));
      chk($sformatf("opcode %0d zero", i), 32'(bz[i]), 32'd0);
    end
    chk("n1 xor out", 32'(n1_out), 32'd0);
    chk("n1 xor zero", 32'(n1_zero), 32'd1);
    chk("n1 xor valid", 32'(n1_valid), 32'd1);
    beat(4'b1010, 4'b0100, 4'b1110);
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid reset out", 32'(out), 32'd0);
    chk("mid reset out_valid", 32'(out_valid), 32'd0);
    chk("mid reset zero", 32'(zero), 32'd1);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("after reset out_valid", 32'(out_valid), 32'd0);
    p0 = pops;
    beat(4'b0010, 4'b1000, 4'b1010);
    idle();
    @(posedge clk);
    #2;
    chk("after reset beat popped", 32'(pops - p0), 32'd1);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/p1_rtl.md
Name: p1_rtl

Overview:
Parameterised N-bit bitwise logic unit. Each valid input beat applies one fixed logic operation, selected at elaboration by parameter opcode, to operands in0 and in1. The result is registered with a one-cycle latency. The block is a leaf datapath primitive in the session-2 logic block set; the default configuration used by the team is opcode=1 (bitwise OR).

Parameters:
N, 4, operand and result width in bits; legal range 1..64.
opcode, 1, 3-bit elaboration-time operation select:
  0 AND
  1 OR
  2 XOR
  3 XNOR
  4 NAND
  5 NOR
  6 ANDN (in0 & ~in1)
  7 PASS (in0)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  qualifies in0/in1 this cycle
in0  input  N  operand A
in1  input  N  operand B
out  output  N  registered result
out_valid  output  1  out holds the result of the beat accepted on the previous edge
zero  output  1  registered; 1 when out == 0

Behaviour:
- Reset (rst_n=0, asynchronous, independent of clk):
  - out=0, out_valid=0, zero=1.
  - Outputs hold these values while rst_n is low.
- First rising edge after rst_n deasserts operates normally; no extra wait cycles.
- Rising edge with in_valid=1:
  - out <= f_opcode(in0, in1), computed bitwise per bit position.
  - out_valid <= 1.
  - zero <= (f_opcode(in0, in1) == 0).
- Rising edge with in_valid=0:
  - out and zero hold their previous values.
  - out_valid <= 0.
- Latency is exactly 1 cycle; throughput is one beat per cycle, with no backpressure.
- Results have width exactly N. There is no carry or overflow. Every bit is independent; no cross-bit logic.
- opcode is constant. An opcode value outside 0..7 (only possible if a wider value is passed) is a fatal elaboration error; use a generate-time check.
- X/Z on in0/in1 when in_valid=0 must not affect outputs.
- Reset asserted mid-stream: outputs clear immediately and the pending result is discarded. After release, out_valid is 0 until the next accepted beat.
- An N=1 instance must synthesise and behave identically per bit.

Test Plan:
- Reset: drive rst_n=0 asynchronously between clock edges -> out=0000, out_valid=0, zero=1 immediately, before the next edge.
- opcode=1, N=4: in0=0101, in1=0011, in_valid=1 -> next edge out=0111, out_valid=1, zero=0. Then in0=0000, in1=0000 -> out=0000, zero=1.
- Random sweep, opcode=1: 100 random in0/in1 beats, back-to-back -> each out equals in0|in1 of the prior beat; out_valid stays 1 throughout.
- Per-opcode, N=4, in0=1100, in1=1010:
  - AND=1000
  - OR=1110
  - XOR=0110
  - XNOR=1001
  - NAND=0111
  - NOR=0001
  - ANDN=0100
  - PASS=1100
- Hold/valid: accept in0=1111, in1=0000 (opcode=1) -> out=1111. Next cycle in_valid=0 with in0=0000 -> out stays 1111 and out_valid drops to 0.
- Reset mid-operation: accept a beat, then pulse rst_n low for less than a clock period before the edge -> out=0 and out_valid=0. After release, the first accepted beat produces the correct result one cycle later.
